decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Reset is reset (synchronous, active-high); clock is clock.
REQ-002 NUM_REGS = 32: register-file depth. Fixed, not a parameter.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ip_instruction  in  32  fetched instruction word from the IF/ID register.
REQ-006 ip_PC_plus_4  in  10  byte address of the next sequential instruction.
REQ-007 ip_wb_write_en / ip_wb_dest_reg / ip_wb_write_data  in  1/5/32  write-back port.
REQ-008 ip_EX_read_en / ip_EX_dest_reg  in  1/5  load in EX (inputs to hazard detection).
REQ-009 ip_flush  in  1  taken branch resolved downstream; kill the instruction in ID.
REQ-010 op_stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-011 op_read_data_1 / op_read_data_2 / op_immediate  out  32 each  registered operands.
REQ-012 op_opcode / op_function_opcode  out  6 each  registered instr[31:26] / instr[5:0].
REQ-013 op_dest_reg_R_type / op_dest_reg_I_type  out  5 each  registered instr[15:11] / instr[20:16].
REQ-014 op_rs / op_rt  out  5 each  registered source register numbers, used by the forwarding unit.
REQ-015 op_PC_plus_4  out  10  registered pass-through.
REQ-016 op_ALU_op[2], op_ALU_src, op_RegDst, op_MemtoReg, op_RegWrite, op_read_en, op_write_en, op_branch  out  registered control.

Function
REQ-017 Register file: 32x32 storage; reg 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-018 Write: on a rising edge, when ip_wb_write_en=1 and ip_wb_dest_reg!=0, the file SHALL store ip_wb_write_data.
REQ-019 Read: asynchronous; when the write port targets the register being read in the same cycle, the read SHALL return ip_wb_write_data (write-before-read bypass).
REQ-020 Immediate: op_immediate SHALL be instr[15:0] sign-extended to 32 bits.
REQ-021 Control decode by opcode:
  - 0x00 (R): RegDst=1, RegWrite=1, ALU_op=10.
  - 0x23 (lw): ALU_src=1, MemtoReg=1, RegWrite=1, read_en=1, ALU_op=00.
  - 0x2B (sw): ALU_src=1, write_en=1, ALU_op=00.
  - 0x04 (beq): branch=1, ALU_op=01.
  - 0x08 (addi): ALU_src=1, RegWrite=1, ALU_op=00.
  - Any other opcode: all control bits 0 (nop).
REQ-022 Hazard: op_stall=1 iff all of the following hold:
  - ip_EX_read_en=1;
  - ip_EX_dest_reg!=0;
  - ip_EX_dest_reg equals rs, or equals rt for an R-type, sw or beq instruction.
REQ-023 Latency: the ID/EX register SHALL update on every rising edge; outputs SHALL reflect the instruction one cycle after it is presented.
REQ-024 Bubble: when op_stall=1, all registered control outputs SHALL load 0; data fields MAY load normally.
REQ-025 Flush: when ip_flush=1, all registered control outputs SHALL load 0, regardless of op_stall.
REQ-026 Priority: reset > flush > stall bubble > normal load.
REQ-027 op_stall SHALL be forced to 0 while ip_flush=1.
REQ-028 A write-back SHALL complete during a stall or flush cycle; neither condition blocks the register-file write port.

Reset
REQ-029 On reset, every registered output SHALL be 0.
REQ-030 On reset, register file entry i SHALL be initialised to value i (i = 0..31).
REQ-031 Reset SHALL override any write-back in the same cycle.
REQ-032 The first instruction after reset deasserts SHALL appear at the outputs one cycle later.

Verification
REQ-033 Reset, then present add $3,$1,$2 (0x00221820) -> next cycle:
  - read_data_1=1, read_data_2=2;
  - dest_R=3, RegDst=1, RegWrite=1, ALU_op=10.
REQ-034 lw $4,-8($5) (0x8CA4FFF8) -> immediate=0xFFFFFFF8, read_data_1=5, ALU_src=1, MemtoReg=1, read_en=1, RegWrite=1.
REQ-035 Same-cycle WB $1<=0xDEADBEEF while decoding add $3,$1,$2 -> read_data_1=0xDEADBEEF.
REQ-036 WB to $0 with 0x1234, then read $0 -> 0.
REQ-037 ip_EX_read_en=1, ip_EX_dest_reg=2, decoding add $3,$1,$2 -> op_stall=1; next cycle all control outputs 0. Repeat with ip_flush=1 -> op_stall=0 and control 0.
REQ-038 beq $1,$2,+3 with opcode 0x3F variant -> opcode 0x3F yields all control bits 0; beq yields branch=1, ALU_op=01, immediate=3.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: 32x32 register file with write-before-read bypass,
// main control decode, load-use hazard detection and the ID/EX pipeline register.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ip_instruction,
  input  logic [9:0]  ip_PC_plus_4,
  input  logic        ip_wb_write_en,
  input  logic [4:0]  ip_wb_dest_reg,
  input  logic [31:0] ip_wb_write_data,
  input  logic        ip_EX_read_en,
  input  logic [4:0]  ip_EX_dest_reg,
  input  logic        ip_flush,
  output logic        op_stall,
  output logic [31:0] op_read_data_1,
  output logic [31:0] op_read_data_2,
  output logic [31:0] op_immediate,
  output logic [5:0]  op_opcode,
  output logic [5:0]  op_function_opcode,
  output logic [4:0]  op_dest_reg_R_type,
  output logic [4:0]  op_dest_reg_I_type,
  output logic [4:0]  op_rs,
  output logic [4:0]  op_rt,
  output logic [9:0]  op_PC_plus_4,
  output logic [1:0]  op_ALU_op,
  output logic        op_ALU_src,
  output logic        op_RegDst,
  output logic        op_MemtoReg,
  output logic        op_RegWrite,
  output logic        op_read_en,
  output logic        op_write_en,
  output logic        op_branch
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       read_en;
    logic       write_en;
    logic       branch;
  } ctrl_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [5:0]        w_opcode;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [DATA_W-1:0] w_read_data_1;
  logic [DATA_W-1:0] w_read_data_2;
  logic              w_wb_valid;
  logic              w_uses_rt;
  logic              w_stall;
  ctrl_t             w_ctrl;
  ctrl_t             r_ctrl;

  assign w_opcode   = ip_instruction[31:26];
  assign w_rs       = ip_instruction[25:21];
  assign w_rt       = ip_instruction[20:16];
  assign w_wb_valid = ip_wb_write_en && (ip_wb_dest_reg != 5'd0);

  // Register file write; reset loads entry i with i and wins over write-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
    end else if (w_wb_valid) begin
      r_regs[ip_wb_dest_reg] <= ip_wb_write_data;
    end
  end

  // Asynchronous reads with same-cycle write-back bypass; $0 is hardwired.
  always_comb begin
    w_read_data_1 = r_regs[w_rs];
    w_read_data_2 = r_regs[w_rt];
    if (w_wb_valid && (ip_wb_dest_reg == w_rs)) w_read_data_1 = ip_wb_write_data;
    if (w_wb_valid && (ip_wb_dest_reg == w_rt)) w_read_data_2 = ip_wb_write_data;
    if (w_rs == 5'd0) w_read_data_1 = '0;
    if (w_rt == 5'd0) w_read_data_2 = '0;
  end

  always_comb begin
    w_ctrl = '0;
    unique case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = 2'b10;
      end
      OP_LW: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.read_en    = 1'b1;
      end
      OP_SW: begin
        w_ctrl.alu_src  = 1'b1;
        w_ctrl.write_en = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = 2'b01;
      end
      OP_ADDI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Load-use hazard: rt only counts for instructions that actually read it.
  always_comb begin
    w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || (w_opcode == OP_BEQ);
    w_stall   = ip_EX_read_en && (ip_EX_dest_reg != 5'd0) &&
                ((ip_EX_dest_reg == w_rs) || (w_uses_rt && (ip_EX_dest_reg == w_rt)));
  end

  assign op_stall = w_stall && !ip_flush;

  // ID/EX register: flush or stall inserts a bubble in the control fields only.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_read_data_1     <= '0;
      op_read_data_2     <= '0;
      op_immediate       <= '0;
      op_opcode          <= '0;
      op_function_opcode <= '0;
      op_dest_reg_R_type <= '0;
      op_dest_reg_I_type <= '0;
      op_rs              <= '0;
      op_rt              <= '0;
      op_PC_plus_4       <= '0;
      r_ctrl             <= '0;
    end else begin
      op_read_data_1     <= w_read_data_1;
      op_read_data_2     <= w_read_data_2;
      op_immediate       <= {{16{ip_instruction[15]}}, ip_instruction[15:0]};
      op_opcode          <= w_opcode;
      op_function_opcode <= ip_instruction[5:0];
      op_dest_reg_R_type <= ip_instruction[15:11];
      op_dest_reg_I_type <= w_rt;
      op_rs              <= w_rs;
      op_rt              <= w_rt;
      op_PC_plus_4       <= ip_PC_plus_4;
      if (ip_flush || w_stall) r_ctrl <= '0;
      else                     r_ctrl <= w_ctrl;
    end
  end

  assign op_ALU_op   = r_ctrl.alu_op;
  assign op_ALU_src  = r_ctrl.alu_src;
  assign op_RegDst   = r_ctrl.reg_dst;
  assign op_MemtoReg = r_ctrl.mem_to_reg;
  assign op_RegWrite = r_ctrl.reg_write;
  assign op_read_en  = r_ctrl.read_en;
  assign op_write_en = r_ctrl.write_en;
  assign op_branch   = r_ctrl.branch;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic [31:0] ip_instruction;
  logic [9:0]  ip_PC_plus_4;
  logic        ip_wb_write_en;
  logic [4:0]  ip_wb_dest_reg;
  logic [31:0] ip_wb_write_data;
  logic        ip_EX_read_en;
  logic [4:0]  ip_EX_dest_reg;
  logic        ip_flush;
  logic        op_stall;
  logic [31:0] op_read_data_1;
  logic [31:0] op_read_data_2;
  logic [31:0] op_immediate;
  logic [5:0]  op_opcode;
  logic [5:0]  op_function_opcode;
  logic [4:0]  op_dest_reg_R_type;
  logic [4:0]  op_dest_reg_I_type;
  logic [4:0]  op_rs;
  logic [4:0]  op_rt;
  logic [9:0]  op_PC_plus_4;
  logic [1:0]  op_ALU_op;
  logic        op_ALU_src;
  logic        op_RegDst;
  logic        op_MemtoReg;
  logic        op_RegWrite;
  logic        op_read_en;
  logic        op_write_en;
  logic        op_branch;

  int n_vec;
  int n_miss;

  // Control word order: {ALU_op[1:0], ALU_src, RegDst, MemtoReg, RegWrite, read_en, write_en, branch}
  localparam logic [8:0] C_NONE = 9'b00_0000000;
  localparam logic [8:0] C_R    = 9'b10_0101000;
  localparam logic [8:0] C_LW   = 9'b00_1011100;
  localparam logic [8:0] C_SW   = 9'b00_1000010;
  localparam logic [8:0] C_BEQ  = 9'b01_0000001;
  localparam logic [8:0] C_ADDI = 9'b00_1001000;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .ip_instruction(ip_instruction), .ip_PC_plus_4(ip_PC_plus_4),
    .ip_wb_write_en(ip_wb_write_en), .ip_wb_dest_reg(ip_wb_dest_reg),
    .ip_wb_write_data(ip_wb_write_data),
    .ip_EX_read_en(ip_EX_read_en), .ip_EX_dest_reg(ip_EX_dest_reg),
    .ip_flush(ip_flush), .op_stall(op_stall),
    .op_read_data_1(op_read_data_1), .op_read_data_2(op_read_data_2),
    .op_immediate(op_immediate), .op_opcode(op_opcode),
    .op_function_opcode(op_function_opcode),
    .op_dest_reg_R_type(op_dest_reg_R_type), .op_dest_reg_I_type(op_dest_reg_I_type),
    .op_rs(op_rs), .op_rt(op_rt), .op_PC_plus_4(op_PC_plus_4),
    .op_ALU_op(op_ALU_op), .op_ALU_src(op_ALU_src), .op_RegDst(op_RegDst),
    .op_MemtoReg(op_MemtoReg), .op_RegWrite(op_RegWrite), .op_read_en(op_read_en),
    .op_write_en(op_write_en), .op_branch(op_branch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({op_ALU_op, op_ALU_src, op_RegDst, op_MemtoReg, op_RegWrite,
                op_read_en, op_write_en, op_branch});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [9:0] pc);
    ip_instruction = instr;
    ip_PC_plus_4   = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] dst, input logic [31:0] data);
    ip_wb_write_en   = en;
    ip_wb_dest_reg   = dst;
    ip_wb_write_data = data;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset = 1'b1;
    ip_EX_read_en = 1'b0;
    ip_EX_dest_reg = 5'd0;
    ip_flush = 1'b0;
    drive(32'h00221820, 10'h3FC);
    wb(1'b1, 5'd1, 32'hFFFF_FFFF);   // must be overridden by reset
    tick();
    tick();
    check("rst_rd1",  op_read_data_1, 32'h0);
    check("rst_imm",  op_immediate, 32'h0);
    check("rst_pc",   32'(op_PC_plus_4), 32'h0);
    check("rst_dest", 32'({op_dest_reg_R_type, op_dest_reg_I_type, op_rs, op_rt}), 32'h0);
    check("rst_ctl",  ctl(), 32'(C_NONE));

    // add $3,$1,$2 right after reset
    reset = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    drive(32'h00221820, 10'h004);
    #1;
    check("add_nostall", 32'(op_stall), 32'h0);
    tick();
    check("add_rd1",   op_read_data_1, 32'd1);
    check("add_rd2",   op_read_data_2, 32'd2);
    check("add_destR", 32'(op_dest_reg_R_type), 32'd3);
    check("add_rsrt",  32'({op_rs, op_rt}), 32'({5'd1, 5'd2}));
    check("add_funct", 32'({op_opcode, op_function_opcode}), 32'h020);
    check("add_ctl",   ctl(), 32'(C_R));
    check("add_pc",    32'(op_PC_plus_4), 32'h004);

    // lw $4,-8($5)
    drive(32'h8CA4FFF8, 10'h008);
    tick();
    check("lw_imm",   op_immediate, 32'hFFFF_FFF8);
    check("lw_rd1",   op_read_data_1, 32'd5);
    check("lw_destI", 32'(op_dest_reg_I_type), 32'd4);
    check("lw_op",    32'(op_opcode), 32'h23);
    check("lw_ctl",   ctl(), 32'(C_LW));

    // sw $4,-8($5) and addi $4,$5,16
    drive(32'hACA4FFF8, 10'h00C);
    tick();
    check("sw_ctl", ctl(), 32'(C_SW));
    check("sw_rd2", op_read_data_2, 32'd4);
    drive(32'h20A40010, 10'h010);
    tick();
    check("addi_ctl", ctl(), 32'(C_ADDI));
    check("addi_imm", op_immediate, 32'h10);

    // same-cycle write-back bypass, then value persists in the file
    drive(32'h00221820, 10'h014);
    wb(1'b1, 5'd1, 32'hDEADBEEF);
    tick();
    check("byp_rd1", op_read_data_1, 32'hDEADBEEF);
    check("byp_rd2", op_read_data_2, 32'd2);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("wr_rd1", op_read_data_1, 32'hDEADBEEF);

    // write to $0 is ignored, both bypass and stored
    drive(32'h00001820, 10'h018);
    wb(1'b1, 5'd0, 32'h1234);
    tick();
    check("r0_byp", op_read_data_1, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("r0_rd1", op_read_data_1, 32'h0);
    check("r0_rd2", op_read_data_2, 32'h0);

    // load-use hazard on rt of R-type; write-back to $7 proceeds during stall
    drive(32'h00221820, 10'h01C);
    ip_EX_read_en  = 1'b1;
    ip_EX_dest_reg = 5'd2;
    wb(1'b1, 5'd7, 32'h0000_0077);
    #1;
    check("hz_stall", 32'(op_stall), 32'h1);
    tick();
    check("hz_bubble", ctl(), 32'(C_NONE));
    wb(1'b0, 5'd0, 32'h0);

    // lw does not read rt: EX dest == rt must not stall; rs match does
    drive(32'h8CA4FFF8, 10'h020);
    ip_EX_dest_reg = 5'd4;
    #1;
    check("hz_lw_rt", 32'(op_stall), 32'h0);
    ip_EX_dest_reg = 5'd5;
    #1;
    check("hz_lw_rs", 32'(op_stall), 32'h1);
    // EX dest $0 never stalls
    drive(32'h00001820, 10'h020);
    ip_EX_dest_reg = 5'd0;
    #1;
    check("hz_r0", 32'(op_stall), 32'h0);

    // flush overrides stall and bubbles control
    drive(32'h00221820, 10'h024);
    ip_EX_dest_reg = 5'd2;
    ip_flush = 1'b1;
    #1;
    check("fl_stall", 32'(op_stall), 32'h0);
    tick();
    check("fl_ctl", ctl(), 32'(C_NONE));
    ip_flush = 1'b0;
    ip_EX_read_en = 1'b0;
    ip_EX_dest_reg = 5'd0;

    // read back $7 written during the stall
    drive(32'h00E00020, 10'h028);
    tick();
    check("stall_wb", op_read_data_1, 32'h77);
    check("norm_ctl", ctl(), 32'(C_R));

    // beq $1,$2,+3 and its unknown-opcode variant
    drive(32'h10220003, 10'h02C);
    tick();
    check("beq_ctl", ctl(), 32'(C_BEQ));
    check("beq_imm", op_immediate, 32'd3);
    drive(32'hFC220003, 10'h030);
    tick();
    check("op3f_ctl", ctl(), 32'(C_NONE));
    check("op3f_op",  32'(op_opcode), 32'h3F);

    // reset again restores register file contents
    reset = 1'b1;
    tick();
    check("rst2_ctl", ctl(), 32'(C_NONE));
    check("rst2_rd1", op_read_data_1, 32'h0);
    reset = 1'b0;
    drive(32'h00221820, 10'h004);
    tick();
    check("rst2_file", op_read_data_1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
